bitwise_exec_unit: RTL and testbench

Multi-cycle bitwise execution stage for the Lab 5 datapath. Holds a small register file, fetches two operands on command, applies one of eight per-bit logic operations (including NAND), and writes the result back. It sits directly upstream of the per-bit logic gate array, whose two operand buses it drives, and downstream of the array, whose output it captures, so the combinational gate arrays become usable from a sequential start/done command interface.

---
 rtl/bitwise_exec_unit.sv | 118 +++++++++++
 tb/tb_bitwise_exec_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bitwise_exec_unit.sv
// Multi-cycle bitwise execution stage: a small register file, operand fetch, a
// per-bit logic lane array and write-back, driven by a start/done handshake.

module bitwise_lane (
  input  logic [2:0] op_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_o
);
  always_comb begin
    y_o = 1'b0;
    case (op_i)
      3'b000: y_o = a_i & b_i;
      3'b001: y_o = a_i | b_i;
      3'b010: y_o = ~(a_i & b_i);
      3'b011: y_o = ~(a_i | b_i);
      3'b100: y_o = a_i ^ b_i;
      3'b101: y_o = ~(a_i ^ b_i);
      3'b110: y_o = ~a_i;
      default: y_o = a_i;
    endcase
  end
endmodule

module bitwise_exec_unit #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rdbg_addr,
  output logic [N-1:0]  rdbg_data,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          zero
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
  state_t state_q, state_d;

  logic [N-1:0]  rf_q [DEPTH];
  logic [2:0]    op_q;
  logic [AW-1:0] ra_q, rb_q, rd_q;
  logic [N-1:0]  opa_q, opb_q, result_q;
  logic          zero_q;
  logic [N-1:0]  f;

  for (genvar g = 0; g < N; g++) begin : g_lane
    bitwise_lane u_lane (.op_i(op_q), .a_i(opa_q[g]), .b_i(opb_q[g]), .y_o(f[g]));
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: state_d = EXEC;
      EXEC:  state_d = WB;
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        op_q <= op;
        ra_q <= ra;
        rb_q <= rb;
        rd_q <= rd;
      end
      if (state_q == FETCH) begin
        opa_q <= rf_q[ra_q];
        opb_q <= rf_q[rb_q];
      end
      if (state_q == EXEC) begin
        result_q <= f;
        zero_q   <= ~|f;
      end
      // Write-back takes the port when a direct load targets the same register.
      if (wr_en && !(state_q == WB && wr_addr == rd_q)) rf_q[wr_addr] <= wr_data;
      if (state_q == WB) rf_q[rd_q] <= result_q;
    end
  end

  assign rdbg_data = rf_q[rdbg_addr];
  assign result    = result_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_bitwise_exec_unit.sv
// Directed bench for bitwise_exec_unit: opcode table, latency, ignored starts,
// write collisions and reset during a command.

module tb_bitwise_exec_unit;
  logic       clk = 0;
  logic       rst, start, wr_en;
  logic [2:0] op;
  logic [1:0] ra, rb, rd, wr_addr, rdbg_addr;
  logic [3:0] wr_data, rdbg_data, result;
  logic       busy, done, zero;

  int n_chk = 0;
  int n_fail = 0;

  bitwise_exec_unit #(.N(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ra(ra), .rb(rb), .rd(rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rdbg_addr(rdbg_addr), .rdbg_data(rdbg_data),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [3:0] exp_res;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [3:0] exp);
    rdbg_addr = a;
    #1;
    chk(name, rdbg_data, exp);
  endtask

  // Issues one command and checks the fixed done/busy timeline around it.
  task automatic run_cmd(input logic [2:0] o, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input string tag);
    op = o; ra = a; rb = b; rd = d; start = 1;
    tick();
    start = 0;
    chk({tag, " busy_fetch"}, busy, 1);
    chk({tag, " done_fetch"}, done, 0);
    tick();
    chk({tag, " done_exec"}, done, 0);
    tick();
    chk({tag, " done_wb"}, done, 1);
    tick();
    chk({tag, " done_after"}, done, 0);
    chk({tag, " busy_after"}, busy, 0);
  endtask

  initial begin
    int dcount;
    vecs[0] = '{3'b000, 2'd0, 2'd1, 4'b1000, 1'b0};
    vecs[1] = '{3'b001, 2'd0, 2'd1, 4'b1110, 1'b0};
    vecs[2] = '{3'b010, 2'd0, 2'd1, 4'b0111, 1'b0};
    vecs[3] = '{3'b011, 2'd0, 2'd1, 4'b0001, 1'b0};
    vecs[4] = '{3'b100, 2'd0, 2'd1, 4'b0110, 1'b0};
    vecs[5] = '{3'b101, 2'd0, 2'd1, 4'b1001, 1'b0};
    vecs[6] = '{3'b110, 2'd0, 2'd1, 4'b0011, 1'b0};
    vecs[7] = '{3'b111, 2'd0, 2'd1, 4'b1100, 1'b0};
    vecs[8] = '{3'b100, 2'd0, 2'd0, 4'b0000, 1'b1};

    rst = 1; start = 0; op = 0; ra = 0; rb = 0; rd = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rdbg_addr = 0;
    tick(); tick();
    rst = 0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset zero", zero, 0);
    for (int i = 0; i < 4; i++) chk_reg($sformatf("reset r%0d", i), 2'(i), 4'b0000);

    // NAND into r2
    load(2'd0, 4'b1100);
    load(2'd1, 4'b1010);
    run_cmd(3'b010, 2'd0, 2'd1, 2'd2, "nand");
    chk("nand result", result, 4'b0111);
    chk("nand zero", zero, 0);
    chk_reg("nand r2", 2'd2, 4'b0111);

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].op, vecs[i].ra, vecs[i].rb, 2'd3, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d zero", i), zero, vecs[i].exp_zero);
      chk_reg($sformatf("vec%0d r3", i), 2'd3, vecs[i].exp_res);
    end

    // Starts raised while busy must be ignored: spurious PASS r0 -> r1 never lands.
    op = 3'b010; ra = 0; rb = 1; rd = 2; start = 1;
    tick();
    op = 3'b111; rd = 1;
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) dcount++;
      tick();
    end
    start = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dcount++;
      tick();
    end
    chk("busy_start done_count", dcount, 1);
    chk_reg("busy_start r1", 2'd1, 4'b1010);

    // start held high: accepts 4 cycles apart
    op = 3'b000; ra = 0; rb = 1; rd = 3; start = 1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) start = 0;
      if (done) dcount++;
    end
    chk("held_start done_count", dcount, 2);
    chk_reg("held_start r3", 2'd3, 4'b1000);

    // Collision on rd: write-back wins
    op = 3'b010; ra = 0; rb = 1; rd = 3; start = 1;
    tick(); start = 0;
    tick(); tick();
    chk("coll_same done", done, 1);
    wr_en = 1; wr_addr = 2'd3; wr_data = 4'b1111;
    tick(); wr_en = 0;
    chk_reg("coll_same r3", 2'd3, 4'b0111);

    // Different addresses: both writes land
    op = 3'b000; ra = 0; rb = 1; rd = 3; start = 1;
    tick(); start = 0;
    tick(); tick();
    wr_en = 1; wr_addr = 2'd2; wr_data = 4'b1111;
    tick(); wr_en = 0;
    chk_reg("coll_diff r3", 2'd3, 4'b1000);
    chk_reg("coll_diff r2", 2'd2, 4'b1111);

    // Reset asserted in EXEC aborts the command
    op = 3'b001; ra = 0; rb = 1; rd = 2; start = 1;
    tick(); start = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("midrst busy", busy, 0);
    chk("midrst result", result, 0);
    chk("midrst zero", zero, 0);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dcount++;
      tick();
    end
    chk("midrst done_count", dcount, 0);
    chk_reg("midrst r2", 2'd2, 4'b0000);

    load(2'd0, 4'b1100);
    load(2'd1, 4'b1010);
    run_cmd(3'b011, 2'd0, 2'd1, 2'd2, "postrst");
    chk("postrst result", result, 4'b0001);
    chk_reg("postrst r2", 2'd2, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
